charlie_matrix: RTL and testbench
=================================

Name: charlie_matrix

Overview:
- Parametrised charlieplexed LED matrix driver; successor to the fixed 7-pin charlie7x5 output stage.
- Scans PINS tri-state pins, driving up to PINS*(PINS-1) LEDs with per-LED PWM brightness and anti-ghosting blanking.
- Double-buffered framebuffer written through a valid/ready port; buffers swap on frame boundaries.
- Sits between the peripheral register block and the board's tri-state pad pairs (charlie_o / charlie_oe).

Parameters:
- PINS, 7, number of charlieplex pins; at least 2.
- LEDS, PINS*(PINS-1), number of addressable LEDs; at most PINS*(PINS-1).
- BW, 4, brightness bits per LED.
- DIV, 4, clocks per PWM step; at least 1.
- BLANK, 2, clocks of all-pins-hi-Z at the start of each anode phase; at least 1.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
- wr_addr  in  $clog2(LEDS)  LED index.
- wr_data  in  BW  brightness level; 0 = off.
- commit  in  1  single-cycle request to present the back buffer.
- commit_done  out  1  single-cycle pulse on the cycle after the swap.
- frame  out  1  single-cycle pulse on the last cycle of each frame.
- charlie_o  out  PINS  pad output values.
- charlie_oe  out  PINS  pad output enables; 0 = hi-Z.

Behaviour:
- Reset (async assert, sync release): charlie_o=0, charlie_oe=0, wr_ready=1, frame=0, commit_done=0, both banks cleared to 0, display bank = 0, commit_pending=0, state=BLANK, anode=0, all counters 0.
- LED mapping: led = a*(PINS-1) + (k<a ? k : k-1), where a is the anode pin and k is the cathode pin (k != a).
- FSM:
  - BLANK: lasts BLANK clocks with all oe=0, then goes to DRIVE.
  - DRIVE: lasts 2^BW steps of DIV clocks each.
- Outputs in DRIVE:
  - Anode pin a: oe=1, o=1.
  - Cathode pin k: oe=1, o=0 when step < level(led), else oe=0.
  - A led index >= LEDS is always off.
  - Outputs are registered and update on the cycle the step or state changes.
- Phase sequencing:
  - At the end of DRIVE, anode increments and the FSM returns to BLANK.
  - After anode PINS-1, anode wraps to 0.
  - Phase length = BLANK + DIV*2^BW clocks; frame length = PINS * phase length.
- frame is high on the final clock of the anode PINS-1 phase.
- Writes:
  - An accepted write updates the back bank (not the displayed bank) at wr_addr on the next edge.
  - wr_addr >= LEDS is accepted (handshake completes) and discarded.
- Commit:
  - commit sets commit_pending; wr_ready=0 while commit_pending=1.
  - On the frame-end edge with commit_pending (or commit high in that same cycle), the display bank toggles, commit_pending clears, wr_ready returns to 1, and commit_done pulses on the following cycle.
  - The new back bank holds the previous front contents; software rewrites it fully.
  - commit while pending is ignored (no double swap).
  - A write accepted in the same cycle as commit lands before the swap.
- Max brightness 2^BW-1 gives (2^BW-1)/2^BW duty; no LED is ever on during BLANK.
- Mid-operation reset returns all outputs to hi-Z immediately (asynchronous), clears both banks, and scanning restarts at anode 0 BLANK.
- No two pins are ever driven with opposite states except the anode high/cathode low pairs.

Test Plan:
- Common settings: PINS=3, LEDS=6, BW=2, DIV=1, BLANK=1; phase = 5 clocks, frame = 15 clocks.
- Reset, no writes -> each phase: 1 clock all oe=0, then 4 clocks oe with only the anode bit set and o=anode bit. frame pulses every 15 clocks; wr_ready=1.
- Write addr0=3, addr3=1, then commit -> wr_ready=0 until the frame end after it, then commit_done pulses for 1 clock.
  - Next frame, anode0 phase: pin1 oe=1 o=0 for 3 steps, hi-Z on step 3.
  - Anode1 phase: pin2 (led3) low for 1 step only.
- Write with no commit -> displayed outputs unchanged for 3 full frames.
- commit asserted on the frame-pulse cycle itself -> swap at that edge, commit_done on the next cycle. A second commit during pending -> exactly one swap.
- Write addr 7 (>= LEDS) with wr_valid -> handshake completes; no LED changes after commit.
- Assert reset_n=0 mid-DRIVE -> charlie_oe=0 within the same cycle without a clock edge. After release, scan restarts at anode0 BLANK with all LEDs off.

Source files
------------

// File: rtl/charlie_matrix.sv
//------------------------------------------------------------------------------
// charlie_matrix
// Parametrised charlieplexed LED matrix driver. It scans PINS tri-state pins,
// applies per-LED PWM brightness, and blanks all pins at the start of every
// anode phase so that no LED ghosts. The framebuffer is double-buffered and
// the displayed bank swaps only on a frame boundary.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module charlie_matrix #(
    parameter int PINS  = 7,
    parameter int LEDS  = PINS * (PINS - 1),
    parameter int BW    = 4,
    parameter int DIV   = 4,
    parameter int BLANK = 2,
    localparam int AW   = (LEDS > 1) ? $clog2(LEDS) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BW-1:0]   wr_data,
    input  logic            commit,
    output logic            commit_done,
    output logic            frame,
    output logic [PINS-1:0] charlie_o,
    output logic [PINS-1:0] charlie_oe
);

    localparam int ANW  = (PINS > 1) ? $clog2(PINS) : 1;
    localparam int CMAX = (BLANK > DIV) ? BLANK : DIV;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]  C_BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0]  C_DIV_LAST   = CW'(DIV - 1);
    localparam logic [BW-1:0]  C_STEP_LAST  = '1;
    localparam logic [ANW-1:0] C_ANODE_LAST = ANW'(PINS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ANW-1:0]  anode_q, anode_d;
    logic [BW-1:0]   step_q,  step_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            frame_q, frame_d;
    logic            bank_q,  bank_d;
    logic            pend_q,  pend_d;
    logic            done_q;
    logic [PINS-1:0] oe_q, oe_d;
    logic [PINS-1:0] o_q,  o_d;

    // Two banks of brightness levels; bank_q selects the displayed one.
    logic [BW-1:0]   mem_q [2][LEDS];

    logic            w_wr_acc;
    logic            w_swap;
    logic [31:0]     w_led;
    logic [BW-1:0]   w_lvl;

    assign w_wr_acc = wr_valid && !pend_q;
    // The swap happens on the edge that ends the frame (frame_q marks that cycle).
    assign w_swap   = frame_q && (pend_q || commit);

    // Phase sequencer: BLANK for BLANK clocks, then 2^BW steps of DIV clocks.
    always_comb begin
        state_d = state_q;
        anode_d = anode_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == C_BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    step_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == C_DIV_LAST) begin
                    cnt_d = '0;
                    if (step_q == C_STEP_LAST) begin
                        state_d = ST_BLANK;
                        step_d  = '0;
                        anode_d = (anode_q == C_ANODE_LAST) ? '0 : anode_q + 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
        // Flag the last clock of the final anode phase one edge ahead so it is registered.
        frame_d = (state_d == ST_DRIVE) && (step_d == C_STEP_LAST) &&
                  (cnt_d == C_DIV_LAST) && (anode_d == C_ANODE_LAST);
    end

    // Commit bookkeeping: pending request and bank toggle at frame end.
    always_comb begin
        bank_d = w_swap ? ~bank_q : bank_q;
        pend_d = w_swap ? 1'b0 : (pend_q | commit);
    end

    // Pad values for the next cycle, derived from the next sequencer state.
    always_comb begin
        oe_d  = '0;
        o_d   = '0;
        w_led = '0;
        w_lvl = '0;
        if (state_d == ST_DRIVE) begin
            for (int p = 0; p < PINS; p++) begin
                if (p == int'(anode_d)) begin
                    oe_d[p] = 1'b1;
                    o_d[p]  = 1'b1;
                end else begin
                    w_led = 32'(int'(anode_d) * (PINS - 1) +
                                ((p < int'(anode_d)) ? p : p - 1));
                    if (w_led < LEDS) begin
                        w_lvl = mem_q[bank_d][w_led[AW-1:0]];
                        if (step_d < w_lvl) begin
                            oe_d[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // State, control and registered pad outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BLANK;
            anode_q <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            anode_q <= anode_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            done_q  <= w_swap;
            oe_q    <= oe_d;
            o_q     <= o_d;
        end
    end

    // Framebuffer writes go to the back bank; out-of-range addresses are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < LEDS; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (w_wr_acc && (32'(wr_addr) < LEDS)) begin
            mem_q[~bank_q][wr_addr] <= wr_data;
        end
    end

    assign wr_ready    = !pend_q;
    assign commit_done = done_q;
    assign frame       = frame_q;
    assign charlie_o   = o_q;
    assign charlie_oe  = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_charlie_matrix.sv
//------------------------------------------------------------------------------
// tb_charlie_matrix
// Directed and randomised bench for charlie_matrix with PINS=3, BW=2, DIV=1,
// BLANK=1. Expected pad states are computed from the elapsed cycle count and
// a two-array framebuffer model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_charlie_matrix;

    localparam int PINS  = 3;
    localparam int LEDS  = 6;
    localparam int BW    = 2;
    localparam int DIV   = 1;
    localparam int BLANK = 1;
    localparam int PH    = BLANK + DIV * (1 << BW);
    localparam int FR    = PINS * PH;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [1:0] wr_data;
    logic       commit;
    logic       commit_done;
    logic       frame;
    logic [2:0] charlie_o;
    logic [2:0] charlie_oe;

    charlie_matrix #(
        .PINS (PINS),
        .LEDS (LEDS),
        .BW   (BW),
        .DIV  (DIV),
        .BLANK(BLANK)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .commit_done(commit_done),
        .frame      (frame),
        .charlie_o  (charlie_o),
        .charlie_oe (charlie_oe)
    );

    always #5 clock = ~clock;

    int nvec  = 0;
    int nfail = 0;
    int t     = 0;
    int m_front [LEDS];
    int m_back  [LEDS];
    bit m_pend;
    bit m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LEDS; i++) begin
            m_front[i] = 0;
            m_back[i]  = 0;
        end
        m_pend = 0;
        m_done = 0;
    endtask

    // Expected pads from cycle position: anode = phase index, step = offset past blanking.
    task automatic chk_outs();
        int an, pos, step, led;
        logic [2:0] eoe, eo;
        an  = (t / PH) % PINS;
        pos = t % PH;
        eoe = '0;
        eo  = '0;
        if (pos >= BLANK) begin
            step    = (pos - BLANK) / DIV;
            eoe[an] = 1'b1;
            eo[an]  = 1'b1;
            for (int k = 0; k < PINS; k++) begin
                if (k != an) begin
                    led = an * (PINS - 1) + ((k < an) ? k : k - 1);
                    if (led < LEDS && step < m_front[led]) eoe[k] = 1'b1;
                end
            end
        end
        chk("charlie_oe", charlie_oe, eoe);
        chk("charlie_o", charlie_o, eo);
        chk("frame", frame, (t % FR) == FR - 1);
        chk("commit_done", commit_done, m_done);
    endtask

    // One clock: apply inputs, advance the model across the edge, check after it.
    task automatic cyc(input bit v, input int a, input int d, input bit c);
        bit dn;
        int tmp;
        wr_valid = v;
        wr_addr  = 3'(a);
        wr_data  = 2'(d);
        commit   = c;
        chk("wr_ready", wr_ready, !m_pend);
        dn = 0;
        if (v && !m_pend && a < LEDS) m_back[a] = d;
        if ((t % FR) == FR - 1 && (m_pend || c)) begin
            for (int i = 0; i < LEDS; i++) begin
                tmp        = m_front[i];
                m_front[i] = m_back[i];
                m_back[i]  = tmp;
            end
            m_pend = 0;
            dn     = 1;
        end else if (c) begin
            m_pend = 1;
        end
        @(posedge clock);
        #1;
        t++;
        m_done = dn;
        chk_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic wait_frame_pos(input int val);
        for (int i = 0; i < FR && (t % FR) != val; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (vectors %0d)", nvec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        commit   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_oe", charlie_oe, 3'b000);
        chk("reset_o", charlie_o, 3'b000);
        chk("reset_ready", wr_ready, 1'b1);
        chk("reset_frame", frame, 1'b0);
        chk("reset_done", commit_done, 1'b0);
        reset_n = 1'b1;
        t = 0;
        chk_outs();

        // Idle scanning: bare anode sweep, frame every FR clocks.
        idle(2 * FR);

        // Two writes and a commit; new image appears from the next frame.
        cyc(1, 0, 3, 0);
        cyc(1, 3, 1, 0);
        cyc(0, 0, 0, 1);
        idle(2 * FR + 3);

        // Writes without commit must not disturb the display for three frames.
        cyc(1, 1, 2, 0);
        cyc(1, 5, 3, 0);
        cyc(1, 0, 1, 0);
        idle(3 * FR);

        // Commit exactly on the frame-pulse cycle swaps at that edge.
        wait_frame_pos(FR - 1);
        cyc(0, 0, 0, 1);
        idle(FR);

        // A second commit while pending yields exactly one swap.
        cyc(1, 2, 3, 0);
        wait_frame_pos(3);
        cyc(0, 0, 0, 1);
        wait_frame_pos(8);
        cyc(0, 0, 0, 1);
        idle(2 * FR);

        // Write and commit in the same cycle: the write lands before the swap.
        wait_frame_pos(FR - 1);
        cyc(1, 4, 2, 1);
        idle(FR);

        // Out-of-range address completes the handshake and is discarded.
        cyc(1, 7, 3, 0);
        cyc(1, 6, 2, 0);
        cyc(0, 0, 0, 1);
        idle(2 * FR);

        // Randomised writes and occasional commits.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 19) == 0);
        end
        idle(FR);

        // Make sure something is lit, then reset in the middle of a DRIVE step.
        cyc(1, 2, 3, 0);
        cyc(1, 3, 3, 0);
        cyc(0, 0, 0, 1);
        idle(FR + 1);
        wait_frame_pos(PH + 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_oe", charlie_oe, 3'b000);
        chk("async_reset_o", charlie_o, 3'b000);
        chk("async_reset_ready", wr_ready, 1'b1);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        t = 0;
        chk_outs();
        idle(2 * FR);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
